line_feeder: RTL and testbench

LINE_FEEDER -- requirements
Module: line_feeder

---
 rtl/spatial_filter_pkg.sv | 29 ++
 rtl/line_feeder_if.sv | 38 +++
 rtl/intr_edge_detect.sv | 33 +++
 rtl/line_feeder.sv | 202 ++++++++++++++++++++
 tb/tb_line_feeder.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spatial_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spatial_filter_pkg
// Description : Shared types and constants for the spatial filter datapath.
//               Holds the line feeder state enumeration and the number of
//               zero-pixel padding lines sent after the image.
//               The PAD_WAIT/PAD states exist only when FEEDER_PAD_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package spatial_filter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    WAIT_INTR = 3'd2,
    LINE      = 3'd3,
`ifdef FEEDER_PAD_EN
    PAD_WAIT  = 3'd4,
    PAD       = 3'd5,
`endif
    FINISH    = 3'd6
  } feeder_state_t;

  // Zero lines appended below the image so the filter window can drain.
  localparam int c_pad_lines = 2;

endpackage
`default_nettype wire

// File: rtl/line_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : line_feeder_if
// Description : Pixel memory read port plus the outgoing pixel stream of the
//               line feeder.
//   master : feeder side  - drives o_mem_rd_en, o_mem_addr, o_m_data_valid,
//                           o_m_data; receives i_mem_data
//   slave  : memory/filter side - the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface line_feeder_if #(
  parameter int ADDR_W = 18
) ();

  logic              o_mem_rd_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        i_mem_data;
  logic              o_m_data_valid;
  logic [7:0]        o_m_data;

  modport master (
    output o_mem_rd_en,
    output o_mem_addr,
    input  i_mem_data,
    output o_m_data_valid,
    output o_m_data
  );

  modport slave (
    input  o_mem_rd_en,
    input  o_mem_addr,
    output i_mem_data,
    input  o_m_data_valid,
    input  o_m_data
  );

endinterface
`default_nettype wire

// File: rtl/intr_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : intr_edge_detect
// Description : Rising-edge detector for the filter's line-buffer-free
//               interrupt. One history register; o_pulse is high for the
//               single cycle in which i_level is high after being low.
//   axis_clk     in  clock
//   axis_reset_n in  asynchronous active-low reset
//   i_level      in  interrupt level
//   o_pulse      out one-cycle rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module intr_edge_detect (
  input  wire logic axis_clk,
  input  wire logic axis_reset_n,
  input  wire logic i_level,
  output logic      o_pulse
);

  logic r_level_d;

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/line_feeder.sv
`default_nettype none
// ============================================================================
// Module      : line_feeder
// Description : Reads an image row-major from pixel memory and streams it to
//               the spatial filter. PRIME_LINES lines are sent up front, then
//               one line per rising edge of i_intr. With FEEDER_PAD_EN
//               defined, two zero lines follow the image, each gated by its
//               own i_intr edge.
//   axis_clk     in  clock
//   axis_reset_n in  asynchronous active-low reset
//   i_start      in  frame start pulse (honoured only when idle)
//   i_intr       in  line-buffer-free interrupt (level)
//   o_busy       out frame in progress
//   o_done       out one-cycle end-of-frame pulse
//   bus          memory read port and pixel stream (line_feeder_if.master)
// Revision    : 1.0 - initial release
// ============================================================================
module line_feeder
  import spatial_filter_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PRIME_LINES  = 4,
  parameter int ADDR_W       = 18
) (
  input  wire logic     axis_clk,
  input  wire logic     axis_reset_n,
  input  wire logic     i_start,
  input  wire logic     i_intr,
  output logic          o_busy,
  output logic          o_done,
  line_feeder_if.master bus
);

  localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int LINE_W = $clog2(IMAGE_HEIGHT + 1);

  localparam logic [COL_W-1:0]  c_col_last   = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [LINE_W-1:0] c_prime_last = LINE_W'(PRIME_LINES - 1);
  localparam logic [LINE_W-1:0] c_lines_all  = LINE_W'(IMAGE_HEIGHT);
  localparam logic [ADDR_W-1:0] c_addr_last  = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  generate
    if ((IMAGE_HEIGHT < PRIME_LINES) || (PRIME_LINES < 1)) begin : g_cfg_check
      $error("line_feeder: IMAGE_HEIGHT must be >= PRIME_LINES >= 1");
    end
  endgenerate

  feeder_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic              r_pending;
  logic              r_rd_d1, r_pad_d1, r_valid;
  logic [7:0]        r_data;

  logic w_intr_edge, w_rd, w_pad, w_consume, w_done;
  logic w_col_last, w_all_read, w_pipe_empty;

  intr_edge_detect u_intr_edge (
    .axis_clk     (axis_clk),
    .axis_reset_n (axis_reset_n),
    .i_level      (i_intr),
    .o_pulse      (w_intr_edge)
  );

  assign w_col_last   = (r_col == c_col_last);
  assign w_all_read   = (r_line == c_lines_all);
  assign w_pipe_empty = ~r_rd_d1 & ~r_pad_d1 & ~r_valid;

`ifdef FEEDER_PAD_EN
  localparam int PAD_W = (c_pad_lines > 1) ? $clog2(c_pad_lines) : 1;
  localparam logic [PAD_W-1:0] c_pad_last = PAD_W'(c_pad_lines - 1);

  logic [PAD_W-1:0] r_pad_line;

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      r_pad_line <= '0;
    end else if (r_state == IDLE) begin
      r_pad_line <= '0;
    end else if (w_pad && w_col_last) begin
      r_pad_line <= r_pad_line + PAD_W'(1);
    end
  end
`endif

  // Next state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_pad       = 1'b0;
    w_consume   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_rd = 1'b1;
        if (w_col_last && (r_line == c_prime_last)) w_state_nxt = WAIT_INTR;
      end
      WAIT_INTR: begin
        if (w_all_read) begin
`ifdef FEEDER_PAD_EN
          w_state_nxt = PAD_WAIT;
`else
          w_state_nxt = FINISH;
`endif
        end else if (w_intr_edge || r_pending) begin
          w_consume   = 1'b1;
          w_state_nxt = LINE;
        end
      end
      LINE: begin
        w_rd = 1'b1;
        if (w_col_last) w_state_nxt = WAIT_INTR;
      end
`ifdef FEEDER_PAD_EN
      PAD_WAIT: begin
        if (w_intr_edge || r_pending) begin
          w_consume   = 1'b1;
          w_state_nxt = PAD;
        end
      end
      PAD: begin
        w_pad = 1'b1;
        if (w_col_last) w_state_nxt = (r_pad_line == c_pad_last) ? FINISH : PAD_WAIT;
      end
`endif
      FINISH: begin
        // Hold until the final pixel has been presented downstream.
        if (w_pipe_empty) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address, column/line counters and the single-deep interrupt pending flag.
  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      r_addr    <= '0;
      r_col     <= '0;
      r_line    <= '0;
      r_pending <= 1'b0;
    end else if (r_state == IDLE) begin
      r_addr    <= '0;
      r_col     <= '0;
      r_line    <= '0;
      r_pending <= 1'b0;
    end else begin
      // The address parks on the last pixel rather than running past it.
      if (w_rd && (r_addr != c_addr_last)) r_addr <= r_addr + ADDR_W'(1);
      if (w_rd || w_pad) r_col <= w_col_last ? '0 : r_col + COL_W'(1);
      if (w_rd && w_col_last) r_line <= r_line + LINE_W'(1);
      // Edges during a streaming state are remembered once; w_pad marks the
      // PAD state, which only exists in the padded build.
      if (w_consume) begin
        r_pending <= 1'b0;
      end else if (w_intr_edge && ((r_state == PRIME) || (r_state == LINE) || w_pad)) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Two-stage output pipeline: memory returns data one cycle after the read,
  // and that data is registered once more before leaving the block.
  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      r_rd_d1  <= 1'b0;
      r_pad_d1 <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_rd_d1  <= w_rd;
      r_pad_d1 <= w_pad;
      r_valid  <= r_rd_d1 | r_pad_d1;
      r_data   <= r_rd_d1 ? bus.i_mem_data : 8'h00;
    end
  end

  assign bus.o_mem_rd_en    = w_rd;
  assign bus.o_mem_addr     = r_addr;
  assign bus.o_m_data_valid = r_valid;
  assign bus.o_m_data       = r_data;
  assign o_busy             = (r_state != IDLE);
  assign o_done             = w_done;

endmodule
`default_nettype wire

// File: tb/tb_line_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_feeder
// Description : Self-checking bench for line_feeder (8x8 image, 4 prime
//               lines). Memory holds random bytes; expected streams are
//               derived from the frame rules: image pixels in address order,
//               then zero pad lines when FEEDER_PAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_feeder;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int P    = 4;
  localparam int AW   = 18;
  localparam int NPIX = W * H;
`ifdef FEEDER_PAD_EN
  localparam int PADN = 2;
`else
  localparam int PADN = 0;
`endif
  localparam int NTOT = NPIX + PADN * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic intr  = 1'b0;
  logic busy, done;

  line_feeder_if #(.ADDR_W(AW)) bus ();

  line_feeder #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .PRIME_LINES  (P),
    .ADDR_W       (AW)
  ) dut (
    .axis_clk     (clk),
    .axis_reset_n (rst_n),
    .i_start      (start),
    .i_intr       (intr),
    .o_busy       (busy),
    .o_done       (done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [NPIX];
  int            cyc = 0;
  int            rd_addr_q[$], rd_cyc_q[$], vd_data_q[$], vd_cyc_q[$], done_cyc_q[$];
  int            max_addr = 0;
  logic          s_rd = 1'b0;
  logic [AW-1:0] s_addr = '0;
  int            checks = 0;
  int            failures = 0;

  // Monitor: logs reads, valid pixels and done pulses mid-cycle.
  always @(negedge clk) begin
    s_rd   <= bus.o_mem_rd_en;
    s_addr <= bus.o_mem_addr;
    if (rst_n) begin
      if (bus.o_mem_rd_en) begin
        rd_addr_q.push_back(int'(bus.o_mem_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (bus.o_m_data_valid) begin
        vd_data_q.push_back(int'(bus.o_m_data));
        vd_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (int'(bus.o_mem_addr) > max_addr) max_addr = int'(bus.o_mem_addr);
    end
  end

  // Memory model: data one cycle after the read; garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_rd) bus.i_mem_data <= (int'(s_addr) < NPIX) ? mem[int'(s_addr)] : 8'hEE;
    else      bus.i_mem_data <= 8'($urandom);
  end

  function automatic int exp_pix(int i);
    return (i < NPIX) ? int'(mem[i]) : 0;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr_q.delete(); rd_cyc_q.delete();
    vd_data_q.delete(); vd_cyc_q.delete();
    done_cyc_q.delete();
    max_addr = 0;
  endtask

  task automatic pulse_start(output int scyc);
    start = 1'b1;
    @(negedge clk) scyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_intr();
    intr = 1'b1;
    step($urandom_range(1, 3));
    intr = 1'b0;
  endtask

  // Each pulse lands while the feeder is waiting; enough time follows for
  // the triggered line to finish.
  task automatic feed_lines(int n);
    repeat (n) begin
      step($urandom_range(2, 8));
      pulse_intr();
      step(W + 4);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    logic [AW+11:0] outs;
    rst_n = 1'b0; start = 1'b0; intr = 1'b0;
    step(3);
    outs = {busy, done, bus.o_mem_rd_en, bus.o_m_data_valid, bus.o_mem_addr, bus.o_m_data};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    #1 rst_n = 1'b1;
    step(10);
    checks++;
    if (rd_addr_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: reads %0d busy %b expected 0 reads busy 0", rd_addr_q.size(), busy);
    end
  endtask

  task automatic test_prime();
    int s;
    clear_log();
    pulse_start(s);
    step(50);
    checks++;
    if (vd_data_q.size() != P * W || rd_addr_q.size() != P * W) begin
      failures++;
      $display("FAIL prime_count: pixels %0d reads %0d expected %0d", vd_data_q.size(), rd_addr_q.size(), P * W);
    end
    checks++;
    if (vd_cyc_q.size() == 0 || vd_cyc_q[0] - s != 3) begin
      failures++;
      $display("FAIL prime_latency: got %0d expected 3", (vd_cyc_q.size() == 0) ? -1 : vd_cyc_q[0] - s);
    end
    for (int i = 0; i < P * W && i < vd_data_q.size() && i < rd_cyc_q.size(); i++) begin
      checks++;
      if (vd_data_q[i] != exp_pix(i) || rd_addr_q[i] != i || vd_cyc_q[i] != rd_cyc_q[i] + 2 ||
          (i > 0 && vd_cyc_q[i] != vd_cyc_q[i-1] + 1)) begin
        failures++;
        $display("FAIL prime_pixel[%0d]: data %0d addr %0d lat %0d expected data %0d addr %0d lat 2 contiguous",
                 i, vd_data_q[i], rd_addr_q[i], vd_cyc_q[i] - rd_cyc_q[i], exp_pix(i), i);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL prime_stall_busy: got %b expected 1", busy);
    end
  endtask

  // Continues the frame left stalled by test_prime.
  task automatic test_lines();
    bit ok;
    int last;
    feed_lines(H - P);
    checks++;
    if (vd_data_q.size() != NPIX) begin
      failures++;
      $display("FAIL lines_count: got %0d expected %0d", vd_data_q.size(), NPIX);
    end
    checks++;
    if (max_addr > NPIX - 1) begin
      failures++;
      $display("FAIL addr_bound: got %0d expected <= %0d", max_addr, NPIX - 1);
    end
`ifdef FEEDER_PAD_EN
    checks++;
    if (done_cyc_q.size() != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pad_wait: done %0d busy %b expected 0 and 1", done_cyc_q.size(), busy);
    end
    feed_lines(1);
    checks++;
    if (vd_data_q.size() != NPIX + W) begin
      failures++;
      $display("FAIL pad_first_line: got %0d expected %0d", vd_data_q.size(), NPIX + W);
    end
    feed_lines(PADN - 1);
`endif
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lines_timeout: busy %b expected 0", busy);
    end
    checks++;
    if (vd_data_q.size() != NTOT) begin
      failures++;
      $display("FAIL frame_count: got %0d expected %0d", vd_data_q.size(), NTOT);
    end
    for (int i = 0; i < vd_data_q.size() && i < NTOT; i++) begin
      checks++;
      if (vd_data_q[i] != exp_pix(i) ||
          (i < NPIX && i < rd_cyc_q.size() && (vd_cyc_q[i] != rd_cyc_q[i] + 2 || rd_addr_q[i] != i)) ||
          (i > 0 && (i < P * W || (i % W) != 0) && vd_cyc_q[i] != vd_cyc_q[i-1] + 1) ||
          (i >= P * W && (i % W) == 0 && vd_cyc_q[i] <= vd_cyc_q[i-1] + 1)) begin
        failures++;
        $display("FAIL frame_pixel[%0d]: data %0d cyc %0d expected data %0d with 2-cycle latency and line framing",
                 i, vd_data_q[i], vd_cyc_q[i], exp_pix(i));
      end
    end
    last = (vd_cyc_q.size() > 0) ? vd_cyc_q[vd_cyc_q.size() - 1] : 0;
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] <= last || done_cyc_q[0] > last + 2) begin
      failures++;
      $display("FAIL done_pulse: count %0d cyc %0d expected 1 pulse after last pixel cyc %0d",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, last);
    end
  endtask

  task automatic test_pending();
    int s;
    bit ok;
    clear_log();
    pulse_start(s);
    step(4);
    pulse_intr();
    step(6);
    pulse_intr();
    step(50);
    checks++;
    if (vd_data_q.size() != (P + 1) * W || rd_addr_q.size() != (P + 1) * W) begin
      failures++;
      $display("FAIL pending_count: pixels %0d reads %0d expected %0d", vd_data_q.size(), rd_addr_q.size(), (P + 1) * W);
    end
    for (int i = 0; i < vd_data_q.size() && i < (P + 1) * W; i++) begin
      checks++;
      if (vd_data_q[i] != exp_pix(i)) begin
        failures++;
        $display("FAIL pending_pixel[%0d]: got %0d expected %0d", i, vd_data_q[i], exp_pix(i));
      end
    end
    feed_lines(H - P - 1 + PADN);
    wait_idle(ok);
    checks++;
    if (!ok || vd_data_q.size() != NTOT || done_cyc_q.size() != 1) begin
      failures++;
      $display("FAIL pending_frame: idle %0b pixels %0d done %0d expected 1 %0d 1", ok, vd_data_q.size(), NTOT, done_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    logic [AW+11:0] outs;
    clear_log();
    pulse_start(s);
    step(40);
    intr = 1'b1;
    step(1);
    intr = 1'b0;
    step(3);
    #1 rst_n = 1'b0;
    #1 outs = {busy, done, bus.o_mem_rd_en, bus.o_m_data_valid, bus.o_mem_addr, bus.o_m_data};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h expected 0", outs);
    end
    step(3);
    rst_n = 1'b1;
    checks++;
    if (done_cyc_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_done: got %0d expected 0", done_cyc_q.size());
    end
    clear_log();
    step(10);
    checks++;
    if (rd_addr_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle: reads %0d busy %b expected 0 0", rd_addr_q.size(), busy);
    end
    pulse_start(s);
    step(40);
    checks++;
    if (rd_addr_q.size() == 0 || rd_addr_q[0] != 0) begin
      failures++;
      $display("FAIL restart_addr: got %0d expected 0", (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1);
    end
    feed_lines(H - P + PADN);
    wait_idle(ok);
    checks++;
    if (!ok || vd_data_q.size() != NTOT || done_cyc_q.size() != 1) begin
      failures++;
      $display("FAIL restart_frame: idle %0b pixels %0d done %0d expected 1 %0d 1", ok, vd_data_q.size(), NTOT, done_cyc_q.size());
    end
  endtask

  task automatic test_start_held();
    bit ok;
    clear_log();
    start = 1'b1;
    step(45);
    feed_lines(2);
    start = 1'b0;
    feed_lines(H - P - 2 + PADN);
    wait_idle(ok);
    checks++;
    if (!ok || rd_addr_q.size() != NPIX || done_cyc_q.size() != 1 || vd_data_q.size() != NTOT) begin
      failures++;
      $display("FAIL held_frame: idle %0b reads %0d done %0d pixels %0d expected 1 %0d 1 %0d",
               ok, rd_addr_q.size(), done_cyc_q.size(), vd_data_q.size(), NPIX, NTOT);
    end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      checks++;
      if (rd_addr_q[i] != i) begin
        failures++;
        $display("FAIL held_addr[%0d]: got %0d expected %0d", i, rd_addr_q[i], i);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    bus.i_mem_data = 8'h00;
    test_reset();
    test_prime();
    test_lines();
    test_pending();
    test_reset_mid();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
